// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file, immediate formatter, RAW/WAW scoreboard, valid/ready output bundle.
// Optional DECODE_BYPASS_EN forwards same-cycle writeback data and busy-clears into the read/hazard path.
module decode_issue_stage #(
    parameter int              XLEN     = 32,
    parameter int              NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_inc,
    input  logic            i_flush,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_inc,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [4:0]      o_rd,
    output logic            o_rd_wr,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);
    localparam int RW = $clog2(NUM_REGS);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_t;

    function automatic logic in_range(input logic [4:0] idx);
        return ({27'd0, idx} < 32'(NUM_REGS));
    endfunction

    logic [XLEN-1:0]     regs_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_eff_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clear_mask_s;
    logic [NUM_REGS-1:0] busy_next_s;

    fmt_t            fmt_s;
    logic [31:0]     imm32_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    logic            rs1_used_s;
    logic            rs2_used_s;
    logic            rd_used_s;
    logic            illegal_s;
    logic            rd_wr_s;
    logic            hazard_s;
    logic            held_wr_s;
    logic            capture_s;
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;

    // Opcode classification and immediate assembly.
    always_comb begin
        rs1_s   = i_inst[19:15];
        rs2_s   = i_inst[24:20];
        rd_s    = i_inst[11:7];
        fmt_s   = FMT_BAD;
        imm32_s = 32'h0000_0000;
        case (i_inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                fmt_s   = FMT_I;
                imm32_s = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            OP_STORE: begin
                fmt_s   = FMT_S;
                imm32_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            OP_BRANCH: begin
                fmt_s   = FMT_B;
                imm32_s = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_s   = FMT_U;
                imm32_s = {i_inst[31:12], 12'h000};
            end
            OP_JAL: begin
                fmt_s   = FMT_J;
                imm32_s = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            end
            OP_REG: begin
                fmt_s   = FMT_R;
                imm32_s = 32'h0000_0000;
            end
            default: begin
                fmt_s   = FMT_BAD;
                imm32_s = 32'h0000_0000;
            end
        endcase
        rs1_used_s = (fmt_s == FMT_R) || (fmt_s == FMT_I) || (fmt_s == FMT_S) || (fmt_s == FMT_B);
        rs2_used_s = (fmt_s == FMT_R) || (fmt_s == FMT_S) || (fmt_s == FMT_B);
        rd_used_s  = (fmt_s == FMT_R) || (fmt_s == FMT_I) || (fmt_s == FMT_U) || (fmt_s == FMT_J);
        illegal_s  = (fmt_s == FMT_BAD) ||
                     (rs1_used_s && !in_range(rs1_s)) ||
                     (rs2_used_s && !in_range(rs2_s)) ||
                     (rd_used_s  && !in_range(rd_s));
        rd_wr_s    = rd_used_s && (rd_s != 5'd0) && !illegal_s;
    end

    // Scoreboard set/clear masks; a same-register set overrides the clear.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            set_mask_s[i]   = o_valid && i_ready && o_rd_wr && (o_rd == 5'(i));
            clear_mask_s[i] = i_wb_en && (i_wb_addr == 5'(i));
        end
        busy_next_s    = (busy_r & ~clear_mask_s) | set_mask_s;
        busy_next_s[0] = 1'b0;
`ifdef DECODE_BYPASS_EN
        busy_eff_s = busy_r & ~clear_mask_s;
`else
        busy_eff_s = busy_r;
`endif
    end

    // Operand read with x0 and out-of-range indices returning zero.
    always_comb begin
        if ((rs1_s != 5'd0) && in_range(rs1_s)) begin
            rs1_data_s = regs_r[rs1_s[RW-1:0]];
        end else begin
            rs1_data_s = {XLEN{1'b0}};
        end
        if ((rs2_s != 5'd0) && in_range(rs2_s)) begin
            rs2_data_s = regs_r[rs2_s[RW-1:0]];
        end else begin
            rs2_data_s = {XLEN{1'b0}};
        end
`ifdef DECODE_BYPASS_EN
        if (i_wb_en && (i_wb_addr == rs1_s) && (rs1_s != 5'd0)) begin
            rs1_data_s = i_wb_data;
        end else begin
            rs1_data_s = rs1_data_s;
        end
        if (i_wb_en && (i_wb_addr == rs2_s) && (rs2_s != 5'd0)) begin
            rs2_data_s = i_wb_data;
        end else begin
            rs2_data_s = rs2_data_s;
        end
`endif
    end

    // Hazard against busy registers and against the destination still held at the output.
    always_comb begin
        held_wr_s = o_valid && o_rd_wr;
        hazard_s  = 1'b0;
        if (rs1_used_s && in_range(rs1_s)) begin
            hazard_s = hazard_s || busy_eff_s[rs1_s[RW-1:0]] || (held_wr_s && (rs1_s == o_rd));
        end else begin
            hazard_s = hazard_s;
        end
        if (rs2_used_s && in_range(rs2_s)) begin
            hazard_s = hazard_s || busy_eff_s[rs2_s[RW-1:0]] || (held_wr_s && (rs2_s == o_rd));
        end else begin
            hazard_s = hazard_s;
        end
        if (rd_wr_s) begin
            hazard_s = hazard_s || busy_eff_s[rd_s[RW-1:0]] || (held_wr_s && (rd_s == o_rd));
        end else begin
            hazard_s = hazard_s;
        end
    end

    assign o_ready   = (!o_valid || i_ready) && !(i_valid && hazard_s) && !i_flush;
    assign capture_s = i_valid && o_ready;

    // Register array; x0 is never written so it reads as zero.
    always_ff @(posedge clk) begin
        if (i_wb_en && (i_wb_addr != 5'd0) && in_range(i_wb_addr)) begin
            regs_r[i_wb_addr[RW-1:0]] <= i_wb_data;
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else if (i_flush) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Output bundle: loads on capture, holds while stalled downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid    <= 1'b0;
            o_inst     <= 32'h0000_0000;
            o_pc       <= RESET_PC;
            o_pc_inc   <= {XLEN{1'b0}};
            o_rs1_data <= {XLEN{1'b0}};
            o_rs2_data <= {XLEN{1'b0}};
            o_rd       <= 5'd0;
            o_rd_wr    <= 1'b0;
            o_imm      <= {XLEN{1'b0}};
            o_illegal  <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (capture_s) begin
            o_valid    <= 1'b1;
            o_inst     <= i_inst;
            o_pc       <= i_pc;
            o_pc_inc   <= i_pc_inc;
            o_rs1_data <= rs1_data_s;
            o_rs2_data <= rs2_data_s;
            o_rd       <= rd_s;
            o_rd_wr    <= rd_wr_s;
            o_imm      <= XLEN'($signed(imm32_s));
            o_illegal  <= illegal_s;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
